instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch: instruction prefetch unit.
//
// Issues word-aligned read requests to instruction memory. Returned words go
// into a small prefetch FIFO that feeds the pipeline, together with their
// addresses. A request may be outstanding while the FIFO fills, and that
// request counts against FIFO capacity, so the FIFO can never overflow.
// A redirect flushes the FIFO and restarts fetching at the new address.
// If a request is still outstanding when the redirect arrives, the FSM holds
// the request until memory acknowledges it and drops the returned data.
//
// Ports:
//   clk            single clock; all state updates on the rising edge
//   reset          synchronous, active-low (0 = reset)
//   mem_req        instruction memory read request
//   mem_addr       word address of the current request (bits [1:0] = 00)
//   mem_ack        memory completes the request this cycle
//   mem_rdata      instruction word, valid with mem_ack
//   if_valid       if_instr/if_pc hold a valid instruction
//   if_instr       instruction word at the FIFO head
//   if_pc          address of if_instr
//   if_ready       pipeline consumes the head this cycle when if_valid=1
//   redirect_valid taken branch/jump: discard all prefetched state
//   redirect_pc    new fetch address (bits [1:0] ignored)
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] PC_INIT = 32'h8002_0000,
    parameter int          DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        DRAIN = 2'b10
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [31:0]   fetch_pc_r;
    logic [31:0]   fetch_pc_s;
    logic [31:0]   mem_addr_r;
    logic [31:0]   mem_addr_s;
    logic          mem_req_r;

    logic [31:0]   fifo_pc_r    [DEPTH];
    logic [31:0]   fifo_instr_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] wr_ptr_s;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] rd_ptr_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_s;
    logic [CW-1:0] count_pop_s;
    logic          push_s;
    logic          pop_s;

    logic          if_valid_r;
    logic [31:0]   if_instr_r;
    logic [31:0]   if_pc_r;
    logic [31:0]   head_instr_s;
    logic [31:0]   head_pc_s;
    logic [31:0]   redirect_aligned_s;

    // FIFO push/pop qualification and next occupancy/pointers; a redirect
    // flushes everything and blocks both push and pop in its cycle.
    always_comb begin
        redirect_aligned_s = redirect_pc & 32'hFFFF_FFFC;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        count_pop_s = count_r;
        count_s     = count_r;
        rd_ptr_s    = rd_ptr_r;
        wr_ptr_s    = wr_ptr_r;
        if (redirect_valid) begin
            count_pop_s = {CW{1'b0}};
            count_s     = {CW{1'b0}};
            rd_ptr_s    = {AW{1'b0}};
            wr_ptr_s    = {AW{1'b0}};
        end else begin
            // mem_ack only counts while a live (non-draining) request is up
            push_s      = (state_r == REQ) && mem_ack;
            pop_s       = if_valid_r && if_ready;
            count_pop_s = count_r - {{(CW-1){1'b0}}, pop_s};
            count_s     = count_pop_s + {{(CW-1){1'b0}}, push_s};
            rd_ptr_s    = rd_ptr_r + {{(AW-1){1'b0}}, pop_s};
            wr_ptr_s    = wr_ptr_r + {{(AW-1){1'b0}}, push_s};
        end
    end

    // Next head entry for the registered pipeline outputs; a word pushed into
    // an (effectively) empty FIFO bypasses storage to keep 1-cycle latency.
    always_comb begin
        head_pc_s    = if_pc_r;
        head_instr_s = if_instr_r;
        if (push_s && (count_pop_s == {CW{1'b0}})) begin
            head_pc_s    = fetch_pc_r;
            head_instr_s = mem_rdata;
        end else if (count_s != {CW{1'b0}}) begin
            head_pc_s    = fifo_pc_r[rd_ptr_s];
            head_instr_s = fifo_instr_r[rd_ptr_s];
        end else begin
            head_pc_s    = if_pc_r;
            head_instr_s = if_instr_r;
        end
    end

    // Request FSM next state, next fetch address and next request address.
    always_comb begin
        state_s    = state_r;
        fetch_pc_s = fetch_pc_r;
        mem_addr_s = mem_addr_r;

        if (redirect_valid) begin
            fetch_pc_s = redirect_aligned_s;
        end else if ((state_r == REQ) && mem_ack) begin
            fetch_pc_s = fetch_pc_r + 32'd4;
        end else begin
            fetch_pc_s = fetch_pc_r;
        end

        // A new request may start only while occupancy leaves room for it.
        case (state_r)
            IDLE: begin
                if (count_s < DEPTH_C) begin
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    if (count_s < DEPTH_C) begin
                        state_s = REQ;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (redirect_valid) begin
                    state_s = DRAIN;
                end else begin
                    state_s = REQ;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    state_s = REQ;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // While draining, the abandoned request stays on the bus unchanged.
        if (state_s == DRAIN) begin
            mem_addr_s = mem_addr_r;
        end else begin
            mem_addr_s = fetch_pc_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Fetch address and registered memory request outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_r <= PC_INIT;
            mem_addr_r <= PC_INIT;
            mem_req_r  <= 1'b0;
        end else begin
            fetch_pc_r <= fetch_pc_s;
            mem_addr_r <= mem_addr_s;
            mem_req_r  <= (state_s != IDLE);
        end
    end

    // FIFO storage; contents are only meaningful under count_r.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_pc_r[wr_ptr_r]    <= fetch_pc_r;
            fifo_instr_r[wr_ptr_r] <= mem_rdata;
        end
    end

    // FIFO pointers, occupancy and registered head outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            if_valid_r <= 1'b0;
            if_pc_r    <= 32'h0000_0000;
            if_instr_r <= 32'h0000_0000;
        end else begin
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            count_r    <= count_s;
            if_valid_r <= (count_s != {CW{1'b0}});
            if_pc_r    <= head_pc_s;
            if_instr_r <= head_instr_s;
        end
    end

    assign mem_req  = mem_req_r;
    assign mem_addr = mem_addr_r;
    assign if_valid = if_valid_r;
    assign if_pc    = if_pc_r;
    assign if_instr = if_instr_r;

endmodule
